vend_ctrl_param: RTL and testbench

//  Parametrised vending-machine controller: N items, M coin denominations, per-item stock.

---
 rtl/vm_pkg.sv | 26 ++
 rtl/vm_edge_det.sv | 20 ++
 rtl/vend_ctrl_param.sv | 197 +++++++++++++++++++
 tb/tb_vend_ctrl_param.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared types and default constants for the parametrised vending controller.
package vm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_REFUND = 2'd3
  } state_t;

  localparam int          DEF_NUM_ITEMS   = 3;
  localparam int          DEF_CREDIT_W    = 8;
  localparam logic [23:0] DEF_PRICES      = {8'd15, 8'd10, 8'd5};
  localparam logic [15:0] DEF_COIN_VALUES = {8'd10, 8'd5};

  // Price of default item i; indices outside the table read as 0.
  function automatic logic [DEF_CREDIT_W-1:0] slice_price(input int i);
    logic [DEF_CREDIT_W-1:0] p;
    p = '0;
    for (int k = 0; k < DEF_NUM_ITEMS; k++) begin
      if (k == i) p = DEF_PRICES[k*DEF_CREDIT_W +: DEF_CREDIT_W];
    end
    return p;
  endfunction

endpackage

// File: rtl/vm_edge_det.sv
// Registered rising-edge detector: rise is high in the cycle din first goes high.
module vm_edge_det #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise
);

  logic [W-1:0] q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= '0;
    else      q <= din;
  end

  assign rise = din & ~q;

endmodule

// File: rtl/vend_ctrl_param.sv
// Vending controller: credit accumulation, vend with change, refund, per-item stock.
module vend_ctrl_param
  import vm_pkg::*;
#(
  parameter int                              NUM_ITEMS   = 3,
  parameter int                              NUM_COINS   = 2,
  parameter int                              CREDIT_W    = 8,
  parameter int                              SEL_W       = 2,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0]   PRICES      = DEF_PRICES,
  parameter logic [NUM_COINS*CREDIT_W-1:0]   COIN_VALUES = DEF_COIN_VALUES,
  parameter int                              MAX_CREDIT  = 50,
  parameter int                              STOCK_W     = 4,
  parameter int                              STOCK_INIT  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_COINS-1:0] coin,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 cancel,
  input  logic                 restock,
  output logic [NUM_ITEMS-1:0] vend,
  output logic                 change,
  output logic [CREDIT_W-1:0]  rtn,
  output logic [CREDIT_W-1:0]  credit,
  output logic [NUM_ITEMS-1:0] sold_out,
  output logic                 coin_reject,
  output logic                 busy
);

  // Wide enough for credit plus every coin landing at once, so the compare never wraps.
  localparam int SUM_W = CREDIT_W + $clog2(NUM_COINS + 1);

  logic [NUM_COINS-1:0] coin_rise;
  logic                 sel_nz;
  logic                 sel_rise;
  logic                 cancel_rise;

  assign sel_nz = |sel;

  vm_edge_det #(.W(NUM_COINS)) u_coin_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (coin),
    .rise (coin_rise)
  );

  vm_edge_det #(.W(1)) u_sel_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (sel_nz),
    .rise (sel_rise)
  );

  vm_edge_det #(.W(1)) u_cancel_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (cancel),
    .rise (cancel_rise)
  );

  logic [CREDIT_W-1:0] price [NUM_ITEMS];

  for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_price
    assign price[gi] = PRICES[gi*CREDIT_W +: CREDIT_W];
  end

  function automatic logic [SUM_W-1:0] coin_sum(input logic [NUM_COINS-1:0] hits);
    logic [SUM_W-1:0] s;
    s = '0;
    for (int j = 0; j < NUM_COINS; j++) begin
      if (hits[j]) s = s + SUM_W'(COIN_VALUES[j*CREDIT_W +: CREDIT_W]);
    end
    return s;
  endfunction

  function automatic logic [STOCK_W-1:0] dec_sat(input logic [STOCK_W-1:0] s);
    return (s == '0) ? s : s - 1'b1;
  endfunction

  state_t               state, state_nx;
  logic [CREDIT_W-1:0]  credit_q, credit_nx;
  logic [STOCK_W-1:0]   stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0]   stock_nx [NUM_ITEMS];
  logic [NUM_ITEMS-1:0] vend_q, vend_nx;
  logic                 change_q, change_nx;
  logic [CREDIT_W-1:0]  rtn_q, rtn_nx;
  logic [NUM_ITEMS-1:0] sold_out_q, sold_out_nx;
  logic                 reject_q, reject_nx;

  logic [NUM_ITEMS-1:0] sel_hit;
  logic                 sel_ok;
  logic [CREDIT_W-1:0]  sel_price;
  logic [SUM_W-1:0]     coin_total;
  logic                 coin_any;

  // Decode the selection edge to an item and decide whether it can be served.
  always_comb begin
    sel_hit   = '0;
    sel_ok    = 1'b0;
    sel_price = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sel_rise && (sel == SEL_W'(i + 1))) begin
        sel_hit[i] = 1'b1;
        sel_price  = price[i];
        sel_ok     = (stock_q[i] != '0) && (credit_q >= price[i]);
      end
    end
  end

  assign coin_any   = |coin_rise;
  assign coin_total = SUM_W'(credit_q) + coin_sum(coin_rise);

  // Next-state and next-output logic; cancel beats sel beats coins.
  always_comb begin
    state_nx  = state;
    credit_nx = credit_q;
    stock_nx  = stock_q;
    vend_nx   = '0;
    change_nx = 1'b0;
    rtn_nx    = '0;
    reject_nx = 1'b0;

    case (state)
      ST_VEND, ST_REFUND: begin
        state_nx  = ST_IDLE;
        credit_nx = '0;
        reject_nx = coin_any;
      end
      default: begin
        if ((state == ST_IDLE) && restock) begin
          for (int i = 0; i < NUM_ITEMS; i++) stock_nx[i] = STOCK_W'(STOCK_INIT);
        end

        if (cancel_rise && (credit_q != '0)) begin
          state_nx  = ST_REFUND;
          change_nx = 1'b1;
          rtn_nx    = credit_q;
          credit_nx = '0;
          reject_nx = coin_any;
        end else if (sel_ok) begin
          state_nx  = ST_VEND;
          vend_nx   = sel_hit;
          rtn_nx    = credit_q - sel_price;
          change_nx = (credit_q != sel_price);
          credit_nx = '0;
          reject_nx = coin_any;
          for (int i = 0; i < NUM_ITEMS; i++) begin
            if (sel_hit[i]) stock_nx[i] = dec_sat(stock_q[i]);
          end
        end else if (coin_any) begin
          if (coin_total <= SUM_W'(MAX_CREDIT)) begin
            credit_nx = CREDIT_W'(coin_total);
            state_nx  = (credit_nx == '0) ? ST_IDLE : ST_CREDIT;
          end else begin
            reject_nx = 1'b1;
          end
        end
      end
    endcase

    for (int i = 0; i < NUM_ITEMS; i++) sold_out_nx[i] = (stock_nx[i] == '0);
  end

  // ---- register stage: state, credit, stock and all output pulses ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      credit_q   <= '0;
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
      vend_q     <= '0;
      change_q   <= 1'b0;
      rtn_q      <= '0;
      sold_out_q <= '0;
      reject_q   <= 1'b0;
    end else begin
      state      <= state_nx;
      credit_q   <= credit_nx;
      stock_q    <= stock_nx;
      vend_q     <= vend_nx;
      change_q   <= change_nx;
      rtn_q      <= rtn_nx;
      sold_out_q <= sold_out_nx;
      reject_q   <= reject_nx;
    end
  end

  always_comb begin
    vend        = vend_q;
    change      = change_q;
    rtn         = rtn_q;
    credit      = credit_q;
    sold_out    = sold_out_q;
    coin_reject = reject_q;
    busy        = (state == ST_VEND) || (state == ST_REFUND);
  end

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Table-driven, scoreboarded bench for vend_ctrl_param with default parameters.
module tb_vend_ctrl_param;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] coin;
  logic [1:0] sel;
  logic       cancel;
  logic       restock;
  logic [2:0] vend;
  logic       change;
  logic [7:0] rtn;
  logic [7:0] credit;
  logic [2:0] sold_out;
  logic       coin_reject;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vend_ctrl_param dut (
    .clk         (clk),
    .rst         (rst),
    .coin        (coin),
    .sel         (sel),
    .cancel      (cancel),
    .restock     (restock),
    .vend        (vend),
    .change      (change),
    .rtn         (rtn),
    .credit      (credit),
    .sold_out    (sold_out),
    .coin_reject (coin_reject),
    .busy        (busy)
  );

  typedef struct packed {
    logic [1:0] coin;
    logic [1:0] sel;
    logic       cancel;
    logic       restock;
    logic [2:0] vend;
    logic       change;
    logic [7:0] rtn;
    logic [7:0] credit;
    logic [2:0] sold_out;
    logic       reject;
    logic       busy;
  } vec_t;

  // Output order: vend, change, rtn, credit, sold_out, reject, busy
  logic [24:0] exp_q [$];
  int          id_q  [$];
  vec_t        tbl   [$];

  function automatic vec_t mk(input logic [1:0] c, input logic [1:0] s, input logic x,
                              input logic r, input logic [2:0] v, input logic ch,
                              input logic [7:0] rt, input logic [7:0] cr,
                              input logic [2:0] so, input logic rj, input logic b);
    vec_t t;
    t.coin = c; t.sel = s; t.cancel = x; t.restock = r;
    t.vend = v; t.change = ch; t.rtn = rt; t.credit = cr;
    t.sold_out = so; t.reject = rj; t.busy = b;
    return t;
  endfunction

  function automatic logic [24:0] actual();
    return {vend, change, rtn, credit, sold_out, coin_reject, busy};
  endfunction

  task automatic check_out();
    logic [24:0] e;
    logic [24:0] a;
    int          id;
    checks++;
    a = actual();
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty got=%b", a);
    end else begin
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      if (a !== e) begin
        errors++;
        $display("FAIL step %0d got vend=%b chg=%b rtn=%0d cr=%0d so=%b rej=%b busy=%b want vend=%b chg=%b rtn=%0d cr=%0d so=%b rej=%b busy=%b",
                 id, a[24:22], a[21], a[20:13], a[12:5], a[4:2], a[1], a[0],
                 e[24:22], e[21], e[20:13], e[12:5], e[4:2], e[1], e[0]);
      end
    end
  endtask

  task automatic apply(input vec_t v, input int id);
    @(negedge clk);
    coin    = v.coin;
    sel     = v.sel;
    cancel  = v.cancel;
    restock = v.restock;
    exp_q.push_back({v.vend, v.change, v.rtn, v.credit, v.sold_out, v.reject, v.busy});
    id_q.push_back(id);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (actual() !== 25'd0) begin
      errors++;
      $display("FAIL %s got=%b want=0", name, actual());
    end
  endtask

  // Insert a 5 coin then select item 0 (exact price), then release.
  task automatic vend0(input logic [2:0] so_before, input logic [2:0] so_after, input int id);
    apply(mk(2'b01, 2'd0, 0, 0, 3'b000, 0, 8'd0, 8'd5, so_before, 0, 0), id);
    apply(mk(2'b00, 2'd1, 0, 0, 3'b001, 0, 8'd0, 8'd0, so_after,  0, 1), id + 1);
    apply(mk(2'b00, 2'd0, 0, 0, 3'b000, 0, 8'd0, 8'd0, so_after,  0, 0), id + 2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; coin = '0; sel = '0; cancel = 1'b0; restock = 1'b0;

    //        coin  sel   x  r  vend    ch rtn    credit so      rj b
    tbl.push_back(mk(2'b01, 2'd0, 0, 0, 3'b000, 0, 8'd0,  8'd5,  3'b000, 0, 0)); // 0
    tbl.push_back(mk(2'b00, 2'd1, 0, 0, 3'b001, 0, 8'd0,  8'd0,  3'b000, 0, 1));
    tbl.push_back(mk(2'b00, 2'd0, 0, 0, 3'b000, 0, 8'd0,  8'd0,  3'b000, 0, 0));
    tbl.push_back(mk(2'b10, 2'd0, 0, 0, 3'b000, 0, 8'd0,  8'd10, 3'b000, 0, 0)); // 3
    tbl.push_back(mk(2'b00, 2'd1, 0, 0, 3'b001, 1, 8'd5,  8'd0,  3'b000, 0, 1));
    tbl.push_back(mk(2'b00, 2'd0, 0, 0, 3'b000, 0, 8'd0,  8'd0,  3'b000, 0, 0));
    tbl.push_back(mk(2'b01, 2'd0, 0, 0, 3'b000, 0, 8'd0,  8'd5,  3'b000, 0, 0)); // 6
    tbl.push_back(mk(2'b10, 2'd0, 0, 0, 3'b000, 0, 8'd0,  8'd15, 3'b000, 0, 0));
    tbl.push_back(mk(2'b00, 2'd3, 0, 0, 3'b100, 0, 8'd0,  8'd0,  3'b000, 0, 1));
    tbl.push_back(mk(2'b00, 2'd0, 0, 0, 3'b000, 0, 8'd0,  8'd0,  3'b000, 0, 0));
    tbl.push_back(mk(2'b10, 2'd0, 0, 0, 3'b000, 0, 8'd0,  8'd10, 3'b000, 0, 0)); // 10
    tbl.push_back(mk(2'b00, 2'd3, 0, 0, 3'b000, 0, 8'd0,  8'd10, 3'b000, 0, 0));
    tbl.push_back(mk(2'b00, 2'd0, 1, 0, 3'b000, 1, 8'd10, 8'd0,  3'b000, 0, 1));
    tbl.push_back(mk(2'b00, 2'd0, 0, 0, 3'b000, 0, 8'd0,  8'd0,  3'b000, 0, 0));
    for (int k = 1; k <= 5; k++) begin                                            // 14..23
      tbl.push_back(mk(2'b10, 2'd0, 0, 0, 3'b000, 0, 8'd0, 8'(10*k), 3'b000, 0, 0));
      tbl.push_back(mk(2'b00, 2'd0, 0, 0, 3'b000, 0, 8'd0, 8'(10*k), 3'b000, 0, 0));
    end
    tbl.push_back(mk(2'b01, 2'd0, 0, 0, 3'b000, 0, 8'd0,  8'd50, 3'b000, 1, 0)); // 24
    tbl.push_back(mk(2'b00, 2'd0, 0, 0, 3'b000, 0, 8'd0,  8'd50, 3'b000, 0, 0));
    tbl.push_back(mk(2'b01, 2'd0, 1, 0, 3'b000, 1, 8'd50, 8'd0,  3'b000, 1, 1));
    tbl.push_back(mk(2'b00, 2'd0, 0, 0, 3'b000, 0, 8'd0,  8'd0,  3'b000, 0, 0));
    tbl.push_back(mk(2'b11, 2'd0, 0, 0, 3'b000, 0, 8'd0,  8'd15, 3'b000, 0, 0)); // 28
    tbl.push_back(mk(2'b00, 2'd0, 0, 0, 3'b000, 0, 8'd0,  8'd15, 3'b000, 0, 0));
    tbl.push_back(mk(2'b00, 2'd2, 0, 0, 3'b010, 1, 8'd5,  8'd0,  3'b000, 0, 1));
    tbl.push_back(mk(2'b00, 2'd0, 0, 0, 3'b000, 0, 8'd0,  8'd0,  3'b000, 0, 0));
    tbl.push_back(mk(2'b10, 2'd0, 0, 0, 3'b000, 0, 8'd0,  8'd10, 3'b000, 0, 0)); // 32
    tbl.push_back(mk(2'b00, 2'd1, 0, 0, 3'b001, 1, 8'd5,  8'd0,  3'b000, 0, 1));
    tbl.push_back(mk(2'b01, 2'd0, 0, 0, 3'b000, 0, 8'd0,  8'd0,  3'b000, 1, 0));
    tbl.push_back(mk(2'b00, 2'd0, 0, 0, 3'b000, 0, 8'd0,  8'd0,  3'b000, 0, 0));
    tbl.push_back(mk(2'b00, 2'd0, 0, 1, 3'b000, 0, 8'd0,  8'd0,  3'b000, 0, 0)); // 36
    tbl.push_back(mk(2'b00, 2'd0, 0, 0, 3'b000, 0, 8'd0,  8'd0,  3'b000, 0, 0));

    repeat (2) @(negedge clk);
    check_zero("reset_hold");
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero("reset_release");

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Sell out item 0 from a fresh restock.
    for (int n = 0; n < 5; n++) vend0(3'b000, (n == 4) ? 3'b001 : 3'b000, 100 + 3*n);
    apply(mk(2'b01, 2'd0, 0, 0, 3'b000, 0, 8'd0, 8'd5, 3'b001, 0, 0), 200);
    apply(mk(2'b00, 2'd1, 0, 0, 3'b000, 0, 8'd0, 8'd5, 3'b001, 0, 0), 201);
    apply(mk(2'b00, 2'd0, 0, 1, 3'b000, 0, 8'd0, 8'd5, 3'b001, 0, 0), 202);
    apply(mk(2'b00, 2'd0, 1, 0, 3'b000, 1, 8'd5, 8'd0, 3'b001, 0, 1), 203);
    apply(mk(2'b00, 2'd0, 0, 0, 3'b000, 0, 8'd0, 8'd0, 3'b001, 0, 0), 204);
    apply(mk(2'b00, 2'd0, 0, 1, 3'b000, 0, 8'd0, 8'd0, 3'b000, 0, 0), 205);
    apply(mk(2'b00, 2'd0, 0, 0, 3'b000, 0, 8'd0, 8'd0, 3'b000, 0, 0), 206);

    // Reset asserted while the vend pulse is on the outputs.
    apply(mk(2'b01, 2'd0, 0, 0, 3'b000, 0, 8'd0, 8'd5, 3'b000, 0, 0), 300);
    apply(mk(2'b00, 2'd1, 0, 0, 3'b001, 0, 8'd0, 8'd0, 3'b000, 0, 1), 301);
    rst = 1'b0;
    #1;
    check_zero("reset_mid_vend");
    @(negedge clk);
    coin = '0; sel = '0; cancel = 1'b0; restock = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Stock must be back at 5: exactly five more vends empty item 0.
    for (int n = 0; n < 5; n++) vend0(3'b000, (n == 4) ? 3'b001 : 3'b000, 400 + 3*n);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
